// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response channels of the ALU issue stage.
// The sequencer sits on the slave modport; the surrounding system uses master.
interface alu_cmd_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_opcode;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [2:0]  alu_opcode;
   logic [31:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [1:0]  rsp_ovf;
   logic [2:0]  rsp_opcode;

   modport master (
      output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_result, rsp_ovf, rsp_opcode
   );

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_result, rsp_ovf, rsp_opcode
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue stage in front of the 16-bit ALU: buffers commands in a FIFO, holds each
// one on the ALU for HOLD_CYCLES cycles, then returns the result with overflow flags.
module alu_cmd_sequencer #(
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   alu_cmd_sequencer_if.slave bus,
   output logic               err_illegal_o,
   output logic               busy_o,
   output logic [15:0]        op_count_o
);
   localparam int PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [PtrW:0]    FullCount = (PtrW + 1)'(DEPTH);
   localparam logic [HoldW-1:0] HoldLast  = HoldW'(HOLD_CYCLES - 1);
   localparam logic [2:0] OpAdd  = 3'b000;
   localparam logic [2:0] OpMul  = 3'b001;
   localparam logic [2:0] OpSub  = 3'b010;
   localparam logic [2:0] OpIdle = 3'b111;

   typedef enum logic [1:0] {Idle, Drive, Resp} state_e;

   typedef struct packed {
      logic [2:0]  opcode;
      logic [15:0] a;
      logic [15:0] b;
   } cmd_t;

   cmd_t             fifoMem [DEPTH];
   cmd_t             head;
   logic [PtrW-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [PtrW:0]    count_q, count_d;
   state_e           state_q, state_d;
   logic [HoldW-1:0] holdCnt_q, holdCnt_d;
   logic [15:0]      aluA_q, aluA_d, aluB_q, aluB_d;
   logic [2:0]       aluOp_q, aluOp_d;
   logic             rspValid_q, rspValid_d;
   logic [31:0]      rspResult_q, rspResult_d;
   logic [1:0]       rspOvf_q, rspOvf_d;
   logic [2:0]       rspOp_q, rspOp_d;
   logic             errIllegal_q, errIllegal_d;
   logic [15:0]      opCount_q, opCount_d;
   logic             fifoFull, fifoEmpty, accept, push, pop;
   logic [1:0]       ovfNow;

   assign fifoFull  = (count_q == FullCount);
   assign fifoEmpty = (count_q == '0);
   assign accept    = bus.cmd_valid && !fifoFull;
   assign push      = accept && (bus.cmd_opcode != OpIdle);
   assign head      = fifoMem[rdPtr_q];

   // Flags are derived from the live ALU result while the command opcode is still driven.
   always_comb begin
      ovfNow = 2'b00;
      case (aluOp_q)
         OpAdd:   ovfNow = {1'b0, bus.alu_result[16]};
         OpSub:   ovfNow = {1'b0, bus.alu_result[31]};
         OpMul:   ovfNow = {|bus.alu_result[31:16], 1'b0};
         default: ovfNow = 2'b00;
      endcase
   end

   // Sequencer: a pop in Resp happens on the same edge as the response handshake.
   always_comb begin
      state_d     = state_q;
      holdCnt_d   = holdCnt_q;
      aluA_d      = aluA_q;
      aluB_d      = aluB_q;
      aluOp_d     = aluOp_q;
      rspValid_d  = rspValid_q;
      rspResult_d = rspResult_q;
      rspOvf_d    = rspOvf_q;
      rspOp_d     = rspOp_q;
      opCount_d   = opCount_q;
      pop         = 1'b0;
      case (state_q)
         Idle: begin
            if (!fifoEmpty) begin
               pop       = 1'b1;
               aluA_d    = head.a;
               aluB_d    = head.b;
               aluOp_d   = head.opcode;
               holdCnt_d = '0;
               state_d   = Drive;
            end
         end
         Drive: begin
            if (holdCnt_q == HoldLast) begin
               rspResult_d = bus.alu_result;
               rspOvf_d    = ovfNow;
               rspOp_d     = aluOp_q;
               rspValid_d  = 1'b1;
               aluOp_d     = OpIdle;
               state_d     = Resp;
            end else begin
               holdCnt_d = holdCnt_q + HoldW'(1);
            end
         end
         Resp: begin
            if (bus.rsp_ready) begin
               rspValid_d = 1'b0;
               opCount_d  = opCount_q + 16'd1;
               if (!fifoEmpty) begin
                  pop       = 1'b1;
                  aluA_d    = head.a;
                  aluB_d    = head.b;
                  aluOp_d   = head.opcode;
                  holdCnt_d = '0;
                  state_d   = Drive;
               end else begin
                  state_d = Idle;
               end
            end
         end
         default: state_d = Idle;
      endcase
   end

   always_comb begin
      wrPtr_d      = push ? wrPtr_q + PtrW'(1) : wrPtr_q;
      rdPtr_d      = pop ? rdPtr_q + PtrW'(1) : rdPtr_q;
      errIllegal_d = accept && (bus.cmd_opcode == OpIdle);
      count_d      = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (PtrW + 1)'(1);
         2'b01:   count_d = count_q - (PtrW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= Idle;
         holdCnt_q    <= '0;
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         count_q      <= '0;
         aluA_q       <= '0;
         aluB_q       <= '0;
         aluOp_q      <= OpIdle;
         rspValid_q   <= 1'b0;
         rspResult_q  <= '0;
         rspOvf_q     <= '0;
         rspOp_q      <= '0;
         errIllegal_q <= 1'b0;
         opCount_q    <= '0;
      end else begin
         state_q      <= state_d;
         holdCnt_q    <= holdCnt_d;
         wrPtr_q      <= wrPtr_d;
         rdPtr_q      <= rdPtr_d;
         count_q      <= count_d;
         aluA_q       <= aluA_d;
         aluB_q       <= aluB_d;
         aluOp_q      <= aluOp_d;
         rspValid_q   <= rspValid_d;
         rspResult_q  <= rspResult_d;
         rspOvf_q     <= rspOvf_d;
         rspOp_q      <= rspOp_d;
         errIllegal_q <= errIllegal_d;
         opCount_q    <= opCount_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifoMem[wrPtr_q] <= {bus.cmd_opcode, bus.cmd_a, bus.cmd_b};
      end
   end

   assign bus.cmd_ready  = !fifoFull;
   assign bus.alu_a      = aluA_q;
   assign bus.alu_b      = aluB_q;
   assign bus.alu_opcode = aluOp_q;
   assign bus.rsp_valid  = rspValid_q;
   assign bus.rsp_result = rspResult_q;
   assign bus.rsp_ovf    = rspOvf_q;
   assign bus.rsp_opcode = rspOp_q;
   assign err_illegal_o  = errIllegal_q;
   assign busy_o         = (state_q != Idle) || !fifoEmpty;
   assign op_count_o     = opCount_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed scenarios followed by random traffic,
// every cycle compared against an in-order queue of expected responses.
module tb_alu_cmd_sequencer;
   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] res;
      logic [1:0]  ovf;
   } expEntry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        errIllegal;
   logic        busy;
   logic [15:0] opCount;
   int          total = 0;
   int          bad = 0;
   expEntry_t   expQ[$];
   logic [15:0] expOpCount;
   logic        expIllegal;

   alu_cmd_sequencer_if bus ();

   alu_cmd_sequencer #(.DEPTH(4), .HOLD_CYCLES(2)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .bus           (bus),
      .err_illegal_o (errIllegal),
      .busy_o        (busy),
      .op_count_o    (opCount)
   );

   always #5 clk = ~clk;

   // Behaviour of the external 16-bit ALU on zero-extended operands.
   function automatic logic [31:0] aluModel(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] ea;
      logic [31:0] eb;
      logic [31:0] r;
      ea = {16'h0000, a};
      eb = {16'h0000, b};
      case (op)
         3'd0:    r = ea + eb;
         3'd1:    r = ea * eb;
         3'd2:    r = ea - eb;
         3'd3:    r = ea & eb;
         3'd4:    r = ea | eb;
         3'd5:    r = ea ^ eb;
         3'd6:    r = ~ea;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] refOvf(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      longint ua;
      longint ub;
      logic [1:0] f;
      ua = longint'(a);
      ub = longint'(b);
      f = 2'b00;
      if (op == 3'd0 && ua + ub > 65535) f = 2'b01;
      if (op == 3'd1 && ua * ub > 65535) f = 2'b10;
      if (op == 3'd2 && ua < ub) f = 2'b01;
      return f;
   endfunction

   always_comb bus.alu_result = aluModel(bus.alu_opcode, bus.alu_a, bus.alu_b);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      check("op_count", 32'(opCount), 32'(expOpCount));
      check("err_illegal", 32'(errIllegal), 32'(expIllegal));
      check("busy", 32'(busy), 32'(expQ.size() != 0));
      if (expQ.size() == 0) begin
         check("idle_alu_opcode", 32'(bus.alu_opcode), 32'h7);
         check("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      end else if (bus.rsp_valid === 1'b1) begin
         check("rsp_result", bus.rsp_result, expQ[0].res);
         check("rsp_ovf", 32'(bus.rsp_ovf), 32'(expQ[0].ovf));
         check("rsp_opcode", 32'(bus.rsp_opcode), 32'(expQ[0].op));
         check("resp_alu_opcode", 32'(bus.alu_opcode), 32'h7);
      end else if (bus.alu_opcode !== 3'b111) begin
         check("drive_alu_a", 32'(bus.alu_a), 32'(expQ[0].a));
         check("drive_alu_b", 32'(bus.alu_b), 32'(expQ[0].b));
         check("drive_alu_opcode", 32'(bus.alu_opcode), 32'(expQ[0].op));
      end
   endtask

   // One clock: check at the falling edge, then advance the model across the rising edge.
   task automatic tick();
      bit        accNow;
      bit        hsNow;
      expEntry_t e;
      @(negedge clk);
      checkOutput();
      accNow = (bus.cmd_valid === 1'b1) && (bus.cmd_ready === 1'b1);
      hsNow  = (bus.rsp_valid === 1'b1) && (bus.rsp_ready === 1'b1);
      e.op  = bus.cmd_opcode;
      e.a   = bus.cmd_a;
      e.b   = bus.cmd_b;
      e.res = aluModel(bus.cmd_opcode, bus.cmd_a, bus.cmd_b);
      e.ovf = refOvf(bus.cmd_opcode, bus.cmd_a, bus.cmd_b);
      @(posedge clk);
      if (rst) begin
         expQ.delete();
         expOpCount = 16'h0000;
         expIllegal = 1'b0;
      end else begin
         expIllegal = accNow && (e.op == 3'b111);
         if (hsNow) begin
            if (expQ.size() != 0) void'(expQ.pop_front());
            expOpCount = expOpCount + 16'd1;
         end
         if (accNow && e.op != 3'b111) expQ.push_back(e);
      end
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      bit accepted = 1'b0;
      bus.cmd_valid  = 1'b1;
      bus.cmd_opcode = op;
      bus.cmd_a      = a;
      bus.cmd_b      = b;
      for (int n = 0; n < 50 && !accepted; n++) begin
         accepted = (bus.cmd_ready === 1'b1);
         tick();
      end
      check("cmd_accept_timeout", 32'(accepted), 32'h1);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic waitRsp(input string tag);
      int n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check(tag, 32'(bus.rsp_valid), 32'h1);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (expQ.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      check(tag, 32'(expQ.size()), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired before the run finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst            = 1'b1;
      bus.cmd_valid  = 1'b0;
      bus.cmd_opcode = 3'b000;
      bus.cmd_a      = 16'h0000;
      bus.cmd_b      = 16'h0000;
      bus.rsp_ready  = 1'b0;
      expOpCount     = 16'h0000;
      expIllegal     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("rst_err_illegal", 32'(errIllegal), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_op_count", 32'(opCount), 32'h0);
      check("rst_alu_a", 32'(bus.alu_a), 32'h0);
      check("rst_alu_b", 32'(bus.alu_b), 32'h0);
      check("rst_alu_opcode", 32'(bus.alu_opcode), 32'h7);
      check("rst_rsp_result", bus.rsp_result, 32'h0);
      check("rst_rsp_ovf", 32'(bus.rsp_ovf), 32'h0);
      check("rst_rsp_opcode", 32'(bus.rsp_opcode), 32'h0);

      // ADD with carry, latency of three edges
      bus.rsp_ready = 1'b1;
      applyStimulus(3'd0, 16'hFFFF, 16'h0001);
      check("lat_e0_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      tick();
      check("lat_e1_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("lat_e1_alu_opcode", 32'(bus.alu_opcode), 32'h0);
      tick();
      check("lat_e2_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      tick();
      check("lat_e3_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("add_result", bus.rsp_result, 32'h00010000);
      check("add_ovf", 32'(bus.rsp_ovf), 32'h1);
      tick();
      check("add_op_count", 32'(opCount), 32'h1);

      // MUL exceeding 16 bits, SUB with borrow
      applyStimulus(3'd1, 16'h1234, 16'h0100);
      waitRsp("mul_rsp_timeout");
      check("mul_result", bus.rsp_result, 32'h00123400);
      check("mul_ovf", 32'(bus.rsp_ovf), 32'h2);
      tick();
      applyStimulus(3'd2, 16'h0003, 16'h0005);
      waitRsp("sub_rsp_timeout");
      check("sub_result", bus.rsp_result, 32'hFFFFFFFE);
      check("sub_ovf", 32'(bus.rsp_ovf), 32'h1);
      tick();

      // Backpressure: one response held, FIFO full, sixth command stalled
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(3'd0, 16'(16'h1000 + i), 16'(i * 3));
      bus.cmd_valid  = 1'b1;
      bus.cmd_opcode = 3'd0;
      bus.cmd_a      = 16'h0F00;
      bus.cmd_b      = 16'h0100;
      for (int i = 0; i < 3; i++) begin
         check("full_cmd_ready", 32'(bus.cmd_ready), 32'h0);
         check("held_rsp_valid", 32'(bus.rsp_valid), 32'h1);
         check("held_rsp_result", bus.rsp_result, 32'h00001000);
         tick();
      end
      bus.rsp_ready = 1'b1;
      applyStimulus(3'd0, 16'h0F00, 16'h0100);
      drain("backpressure_drain");
      check("backpressure_op_count", 32'(opCount), 32'd9);

      // Illegal opcode
      applyStimulus(3'd7, 16'h00AA, 16'h0055);
      check("illegal_pulse", 32'(errIllegal), 32'h1);
      check("illegal_busy", 32'(busy), 32'h0);
      check("illegal_alu_opcode", 32'(bus.alu_opcode), 32'h7);
      tick();
      check("illegal_pulse_end", 32'(errIllegal), 32'h0);
      check("illegal_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("illegal_op_count", 32'(opCount), 32'd9);

      // Reset during the second hold cycle of an XOR with two commands queued
      applyStimulus(3'd5, 16'h5A5A, 16'h0FF0);
      applyStimulus(3'd4, 16'h1234, 16'h4321);
      applyStimulus(3'd3, 16'hF0F0, 16'h3C3C);
      check("xor_drive_opcode", 32'(bus.alu_opcode), 32'h5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_alu_opcode", 32'(bus.alu_opcode), 32'h7);
      check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_op_count", 32'(opCount), 32'h0);
      repeat (8) tick();
      check("postrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);

      // Random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         bus.cmd_valid  = ($urandom_range(0, 1) == 1);
         bus.cmd_opcode = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
         bus.cmd_a      = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         bus.cmd_b      = 16'($urandom);
         bus.rsp_ready  = ($urandom_range(0, 3) != 0);
         tick();
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      drain("random_drain");
      check("random_op_count", 32'(opCount), 32'(expOpCount));

      // Counter wrap: jump the counter close to its limit instead of issuing 65k commands
      force dut.opCount_q = 16'hFFFE;
      expOpCount = 16'hFFFE;
      tick();
      release dut.opCount_q;
      tick();
      check("preload_op_count", 32'(opCount), 32'h0000FFFE);
      applyStimulus(3'd6, 16'h0000, 16'h0000);
      waitRsp("not_rsp_timeout");
      check("not_result", bus.rsp_result, 32'hFFFFFFFF);
      check("not_ovf", 32'(bus.rsp_ovf), 32'h0);
      tick();
      check("op_count_ffff", 32'(opCount), 32'h0000FFFF);
      applyStimulus(3'd6, 16'h0000, 16'h0000);
      drain("wrap_drain");
      check("op_count_wrap", 32'(opCount), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Issue stage directly upstream of the 16-bit ALU.
- Accepts ALU commands (opcode, A, B) over a valid/ready interface and buffers them in a small FIFO.
- Drives one command at a time onto the ALU operand/opcode lines, held stable for a fixed number of cycles, then captures the ALU's 32-bit result, computes the 2-bit overflow flag, and presents the response downstream with valid/ready.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, >=2.
- HOLD_CYCLES, 2: cycles operands/opcode are held on the ALU before result capture; >=1.

Ports:
- clk  in  1  Clock; all state updates on posedge.
- rst  in  1  Synchronous, active-high reset.
- cmd_valid  in  1  Command offered.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_opcode  in  3  ALU opcode: 000 ADD, 001 MUL, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 NOT, 111 illegal.
- cmd_a  in  16  Operand A.
- cmd_b  in  16  Operand B.
- alu_a  out  16  Registered operand A to the ALU.
- alu_b  out  16  Registered operand B to the ALU.
- alu_opcode  out  3  Registered opcode to the ALU; 3'b111 = idle.
- alu_result  in  32  Combinational ALU result.
- rsp_valid  out  1  Response available.
- rsp_ready  in  1  Downstream accepts the response.
- rsp_result  out  32  Captured result.
- rsp_ovf  out  2  Overflow flag: bit0 carry/borrow, bit1 multiply exceeds 16 bits.
- rsp_opcode  out  3  Opcode of the response.
- err_illegal  out  1  One-cycle pulse when opcode 111 is accepted.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- op_count  out  16  Completed response handshakes; wraps at 0xFFFF->0x0000.

Behaviour:
- Reset values:
  - cmd_ready=1, rsp_valid=0, err_illegal=0, busy=0, op_count=0.
  - alu_a=0, alu_b=0, alu_opcode=3'b111.
  - rsp_result=0, rsp_ovf=0, rsp_opcode=0.
  - FIFO emptied; FSM=IDLE.
- Reset mid-operation discards FIFO contents, any in-flight command and any pending response. No response is emitted for discarded commands.
- Command acceptance:
  - Accept = cmd_valid && cmd_ready.
  - cmd_ready = !fifo_full. It depends on occupancy only, not on a same-cycle pop: when full, no push, even if a pop occurs that cycle.
  - Accepted opcode 111 is not written to the FIFO. err_illegal=1 the following cycle, and op_count is unchanged.
- FSM states IDLE, DRIVE, RESP:
  - IDLE: when FIFO is non-empty, pop the head, load alu_a/alu_b/alu_opcode, reset hold counter, go to DRIVE.
  - DRIVE: alu_* held constant. The hold counter counts HOLD_CYCLES cycles. On the edge ending the last DRIVE cycle:
    - capture alu_result into rsp_result, compute rsp_ovf, copy opcode into rsp_opcode;
    - set rsp_valid=1, alu_opcode=3'b111, go to RESP.
  - RESP: all rsp_* outputs held stable while rsp_valid && !rsp_ready. On handshake, op_count increments and rsp_valid drops. Then:
    - if FIFO is non-empty, pop the next command in the same edge and go to DRIVE (back-to-back);
    - otherwise go to IDLE.
- Latency: command accepted at edge E0 into an empty FIFO with FSM IDLE → alu_* valid after E1 → rsp_valid high after E(1+HOLD_CYCLES), i.e. 3 cycles with the default.
- Steady-state throughput: one response per HOLD_CYCLES+1 cycles when rsp_ready=1.
- Overflow rules, using the captured 32-bit result R:
  - ADD: ovf={1'b0, R[16]}.
  - SUB: ovf={1'b0, R[31]} (borrow when A<B; R wraps in 32 bits).
  - MUL: ovf={|R[31:16], 1'b0}.
  - All other opcodes: ovf=2'b00.
- Commands complete strictly in FIFO (acceptance) order.
- Simultaneous events:
  - A push to an empty FIFO while IDLE is popped on the next edge, never in the same edge.
  - A push and a pop in the same edge keep the occupancy constant.
- alu_opcode is 3'b111 in every cycle outside DRIVE.

Test Plan:
- ADD A=0xFFFF, B=0x0001, rsp_ready=1 → rsp_result=0x00010000, rsp_ovf=2'b01, rsp_valid rises 3 cycles after acceptance, op_count=1.
- MUL A=0x1234, B=0x0100 → rsp_result=0x00123400, rsp_ovf=2'b10. SUB A=0x0003, B=0x0005 → rsp_result=0xFFFFFFFE, rsp_ovf=2'b01.
- rsp_ready=0, offer 6 ADDs back-to-back → first in RESP plus 4 in FIFO, cmd_ready=0 with the 6th pending and rsp_* stable. Then rsp_ready=1 → 6 responses in order, op_count=6, alu_a/alu_b/alu_opcode constant throughout each DRIVE.
- Opcode 111 with A=0x00AA → accepted, err_illegal pulses exactly 1 cycle, no response, alu_opcode stays 111, op_count unchanged.
- Assert rst in the second DRIVE cycle of an XOR with 2 commands queued → next cycle: alu_opcode=111, rsp_valid=0, cmd_ready=1, busy=0, op_count=0, and no responses follow.
- Preload op_count to 0xFFFF via 65535 NOT commands (A=0x0000 → rsp_result=0xFFFFFFFF, ovf=00); one more response → op_count=0x0000.
